// File: rtl/regfile_copy_engine.sv
// rtl/regfile_copy_engine.sv - word-at-a-time copy initiator for a 16x8 register file (optional macro: REGFILE_COPY_CHECKSUM_EN)
module regfile_copy_engine #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] radd,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] wadd,
  output logic [DATA_W-1:0] wdata,
  output logic              writeenable
`ifdef REGFILE_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1 << ADDR_W);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_src;
  logic [ADDR_W-1:0] cur_dst;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   len_clamped;

  // Requests longer than the file are trimmed to one full pass
  assign len_clamped = (len > DEPTH) ? DEPTH : len;

  // Copy sequencer: RD latches the source word into wdata (the hold register), WR strobes it out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_src     <= '0;
      cur_dst     <= '0;
      remaining   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      radd        <= '0;
      wadd        <= '0;
      wdata       <= '0;
      writeenable <= 1'b0;
`ifdef REGFILE_COPY_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur_src   <= src_base;
            cur_dst   <= dst_base;
            remaining <= len_clamped;
`ifdef REGFILE_COPY_CHECKSUM_EN
            checksum  <= '0;
`endif
            if (len_clamped != '0) begin
              state <= RD;
              busy  <= 1'b1;
              radd  <= src_base;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RD: begin
          wdata       <= rdata;
          wadd        <= cur_dst;
          writeenable <= 1'b1;
          state       <= WR;
        end
        WR: begin
          cur_src     <= cur_src + 1'b1;
          cur_dst     <= cur_dst + 1'b1;
          remaining   <= remaining - 1'b1;
          writeenable <= 1'b0;
`ifdef REGFILE_COPY_CHECKSUM_EN
          checksum    <= checksum ^ wdata;
`endif
          if (remaining != (ADDR_W+1)'(1)) begin
            state <= RD;
            radd  <= cur_src + 1'b1;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_copy_engine.sv
// tb/tb_regfile_copy_engine.sv - self-checking bench for regfile_copy_engine against a software copy-loop model
module tb_regfile_copy_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] src_base = '0;
  logic [3:0] dst_base = '0;
  logic [4:0] len = '0;
  logic       busy, done, writeenable;
  logic [3:0] radd, wadd;
  logic [7:0] rdata, wdata;
`ifdef REGFILE_COPY_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  logic [7:0] mem [16];
  logic [7:0] ref_mem [16];
  logic       pl_en = 1'b0;
  logic [3:0] pl_a = '0;
  logic [7:0] pl_d = '0;

  int n_assert = 0;
  int n_fail = 0;
  int we_total = 0;
  int busy_total = 0;
  int done_total = 0;
  logic [3:0] radd_log [$];

  regfile_copy_engine #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
    .len(len), .busy(busy), .done(done), .radd(radd), .rdata(rdata),
    .wadd(wadd), .wdata(wdata), .writeenable(writeenable)
`ifdef REGFILE_COPY_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Register file model: combinational read, DUT write or bench preload on the clock edge
  assign rdata = mem[radd];
  always @(posedge clk) begin
    if (writeenable) mem[wadd] <= wdata;
    else if (pl_en) mem[pl_a] <= pl_d;
  end

  // Activity monitor on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (writeenable) we_total++;
      if (busy) busy_total++;
      if (done) done_total++;
      if (busy && !writeenable) radd_log.push_back(radd);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    ref_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) check($sformatf("%s_mem%0d", tag, i), 32'(mem[i]), 32'(ref_mem[i]));
  endtask

  // Software reference: for (i=0;i<n;i++) mem[dst+i] = mem[src+i], modulo 16
  task automatic model_copy(input int s, input int d, input int n, output logic [7:0] cs);
    cs = '0;
    for (int i = 0; i < n; i++) begin
      cs = cs ^ ref_mem[(s + i) % 16];
      ref_mem[(d + i) % 16] = ref_mem[(s + i) % 16];
    end
  endtask

  task automatic run_copy(input logic [3:0] s, input logic [3:0] d, input logic [4:0] l, input string tag);
    int n, wb, bb, db, cyc;
    logic [7:0] cs;
    n = (l > 16) ? 16 : int'(l);
    model_copy(int'(s), int'(d), n, cs);
    wb = we_total; bb = busy_total; db = done_total;
    start = 1'b1; src_base = s; dst_base = d; len = l;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    @(negedge clk); #1;
    check({tag, "_writes"}, 32'(we_total - wb), 32'(n));
    check({tag, "_busy_cycles"}, 32'(busy_total - bb), 32'(2 * n));
    check({tag, "_done_pulses"}, 32'(done_total - db), 32'd1);
    check_mem(tag);
`ifdef REGFILE_COPY_CHECKSUM_EN
    check({tag, "_checksum"}, 32'(checksum), 32'(cs));
`endif
  endtask

  initial begin
    int wb, bb, db, lb, cyc, seen;
    logic [7:0] cs;

    // Reset phase
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(writeenable), 32'd0);
    check("rst_radd", 32'(radd), 32'd0);
    check("rst_wadd", 32'(wadd), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    #3 rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_we", 32'(writeenable), 32'd0);
    for (int i = 0; i < 16; i++) preload(4'(i), 8'($urandom_range(0, 255)));
    check("rst_no_writes", 32'(we_total), 32'd0);

    // Basic copy
    preload(4'h0, 8'h12); preload(4'h1, 8'h10); preload(4'h2, 8'h17);
    run_copy(4'h0, 4'h8, 5'd3, "basic");
`ifdef REGFILE_COPY_CHECKSUM_EN
    check("basic_checksum_const", 32'(checksum), 32'h15);
`endif
    check("basic_mem8", 32'(mem[8]), 32'h12);
    check("basic_memA", 32'(mem[10]), 32'h17);

    // Wrap-around source and destination
    preload(4'hE, 8'h3D); preload(4'hF, 8'h20);
    lb = radd_log.size();
    run_copy(4'hE, 4'h1, 5'd3, "wrap");
    check("wrap_radd_cnt", 32'(radd_log.size() - lb), 32'd3);
    if (radd_log.size() - lb == 3) begin
      check("wrap_radd0", 32'(radd_log[lb]), 32'hE);
      check("wrap_radd1", 32'(radd_log[lb+1]), 32'hF);
      check("wrap_radd2", 32'(radd_log[lb+2]), 32'h0);
    end

    // Overlapping smear with clamp
    for (int i = 0; i < 16; i++) preload(4'(i), 8'(i));
    run_copy(4'h0, 4'h1, 5'd31, "smear");
    for (int i = 0; i < 16; i++) check($sformatf("smear_zero%0d", i), 32'(mem[i]), 32'd0);

    // Zero-length request
    run_copy(4'h3, 4'h9, 5'd0, "len0");

    // Same source and destination
    for (int i = 0; i < 16; i++) preload(4'(i), 8'($urandom_range(0, 255)));
    run_copy(4'h5, 4'h5, 5'd4, "self");

    // Start while busy, then start held in DONE
    model_copy(2, 12, 4, cs);
    wb = we_total; bb = busy_total; db = done_total;
    start = 1'b1; src_base = 4'h2; dst_base = 4'hC; len = 5'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    start = 1'b1; src_base = 4'h7; dst_base = 4'h0; len = 5'd9;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("bs_done_seen", 32'(done), 32'd1);
    start = 1'b1; src_base = 4'h1; dst_base = 4'h4; len = 5'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("bs_writes", 32'(we_total - wb), 32'd4);
    check("bs_busy_cycles", 32'(busy_total - bb), 32'd8);
    check("bs_done_pulses", 32'(done_total - db), 32'd1);
    check("bs_idle_busy", 32'(busy), 32'd0);
    check_mem("bs");

    // Reset mid-copy: abort during the third write strobe, two words committed
    for (int i = 0; i < 16; i++) preload(4'(i), 8'($urandom_range(0, 255)));
    model_copy(4, 10, 2, cs);
    db = done_total;
    start = 1'b1; src_base = 4'h4; dst_base = 4'hA; len = 5'd5;
    @(negedge clk);
    start = 1'b0;
    seen = 0; cyc = 0;
    while (seen < 3 && cyc < 100) begin
      if (writeenable) seen++;
      if (seen < 3) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("mid_reached_wr3", 32'(seen), 32'd3);
    rst = 1'b1;
    #1;
    check("mid_we_drop", 32'(writeenable), 32'd0);
    check("mid_busy_drop", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_no_done", 32'(done_total - db), 32'd0);
    check_mem("mid");

    // Randomized copies after the abort
    for (int t = 0; t < 12; t++) begin
      if (t % 3 == 0) for (int i = 0; i < 16; i++) preload(4'(i), 8'($urandom_range(0, 255)));
      run_copy(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
               $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
